// File: rtl/bullet_slot_arbiter.sv
// bullet_slot_arbiter
// Shares a pool of NSLOT bullet slots between NREQ bullet sources (enemies 1-4
// and the boss). One slot at most is handed out per game tick. The winner is
// chosen round-robin among sources whose cooldown has expired. The block
// records which source owns each busy slot. A slot is released when the bullet
// datapath pulses its free bit.

module bullet_slot_arbiter #(
  parameter int NREQ     = 5,
  parameter int NSLOT    = 8,
  parameter int COOLDOWN = 4
) (
  input  logic                 clk22,
  input  logic                 rst,
  input  logic                 gamestart,
  input  logic [NREQ-1:0]      req,
  input  logic [NSLOT-1:0]     free,
  output logic                 grant_valid,
  output logic [NREQ-1:0]      grant,
  output logic [2:0]           grant_slot,
  output logic [NSLOT-1:0]     slot_busy,
  output logic [3*NSLOT-1:0]   slot_owner,
  output logic                 full,
  output logic [7:0]           denied_cnt
);

  logic [NSLOT-1:0]       busy_q, busy_d;
  logic [3*NSLOT-1:0]     owner_q, owner_d;
  logic [NREQ-1:0][3:0]   cd_q, cd_d;
  logic [2:0]             rrPtr_q, rrPtr_d;
  logic                   gv_q, gv_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [2:0]             gslot_q, gslot_d;
  logic [7:0]             denied_q, denied_d;

  logic [NREQ-1:0]        eligible;
  logic [2*NREQ-1:0]      eligDup;
  logic [NREQ-1:0]        eligRot;
  logic [2:0]             rotOffset;
  logic [3:0]             winSum;
  logic                   winFound;
  logic [2:0]             winIdx;
  logic                   slotFound;
  logic [2:0]             slotIdx;

  // Eligibility: a source is asking and its cooldown has run out.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NREQ; r++) begin
      eligible[r] = req[r] && (cd_q[r] == 4'd0);
    end
  end

  // Round-robin search: rotate eligibility so rrPtr sits at bit 0, then take the lowest set bit.
  always_comb begin
    eligDup   = {eligible, eligible} >> rrPtr_q;
    eligRot   = eligDup[NREQ-1:0];
    rotOffset = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (eligRot[j]) begin
        rotOffset = 3'(j);
      end
    end
    winFound = |eligRot;
    winSum   = {1'b0, rrPtr_q} + {1'b0, rotOffset};
    if (winSum >= 4'(NREQ)) begin
      winSum = winSum - 4'(NREQ);
    end
    winIdx = winSum[2:0];
  end

  // Lowest-index slot that was free at the start of the tick.
  always_comb begin
    slotIdx = '0;
    for (int k = NSLOT - 1; k >= 0; k--) begin
      if (!busy_q[k]) begin
        slotIdx = 3'(k);
      end
    end
    slotFound = ~&busy_q;
  end

  // Next-state logic: frees, grant, cooldown, denial counting and the game-idle clear.
  always_comb begin
    busy_d   = busy_q;
    owner_d  = owner_q;
    cd_d     = cd_q;
    rrPtr_d  = rrPtr_q;
    gv_d     = 1'b0;
    grant_d  = '0;
    gslot_d  = '0;
    denied_d = denied_q;

    if (!gamestart) begin
      busy_d  = '0;
      owner_d = '0;
      cd_d    = '0;
      rrPtr_d = '0;
    end else begin
      for (int r = 0; r < NREQ; r++) begin
        if (cd_q[r] != 4'd0) begin
          cd_d[r] = cd_q[r] - 4'd1;
        end
      end

      for (int k = 0; k < NSLOT; k++) begin
        if (free[k]) begin
          busy_d[k]          = 1'b0;
          owner_d[3*k +: 3]  = 3'd0;
        end
      end

      if (winFound && slotFound) begin
        for (int k = 0; k < NSLOT; k++) begin
          if (3'(k) == slotIdx) begin
            busy_d[k]         = 1'b1;
            owner_d[3*k +: 3] = winIdx;
          end
        end
        for (int r = 0; r < NREQ; r++) begin
          if (3'(r) == winIdx) begin
            cd_d[r]    = 4'(COOLDOWN);
            grant_d[r] = 1'b1;
          end
        end
        rrPtr_d = (winIdx == 3'(NREQ - 1)) ? 3'd0 : winIdx + 3'd1;
        gv_d    = 1'b1;
        gslot_d = slotIdx;
      end else if (winFound) begin
        if (denied_q != 8'hFF) begin
          denied_d = denied_q + 8'd1;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk22) begin
    if (rst) begin
      busy_q   <= '0;
      owner_q  <= '0;
      cd_q     <= '0;
      rrPtr_q  <= '0;
      gv_q     <= 1'b0;
      grant_q  <= '0;
      gslot_q  <= '0;
      denied_q <= '0;
    end else begin
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      cd_q     <= cd_d;
      rrPtr_q  <= rrPtr_d;
      gv_q     <= gv_d;
      grant_q  <= grant_d;
      gslot_q  <= gslot_d;
      denied_q <= denied_d;
    end
  end

  assign grant_valid = gv_q;
  assign grant       = grant_q;
  assign grant_slot  = gslot_q;
  assign slot_busy   = busy_q;
  assign slot_owner  = owner_q;
  assign full        = &busy_q;
  assign denied_cnt  = denied_q;

endmodule
